// File: rtl/motor_puertas_if.sv
// rtl/motor_puertas_if.sv - door motor command/status bundle
//
// Signals:
//   salida_puertas [1:0] command to the doors: 01 open, 10 close, 00 none, 11 illegal
//   sensor               obstruction between the doors (1 = sensed)
//   puertas        [1:0] door status: 00 closed, 01 open, 10 closing, 11 opening
//   timeout              open-dwell timeout level
//   posicion       [7:0] door position, 0 = closed, T_MOV = open
//   cmd_invalido         one-cycle pulse after an illegal command
//
// master: the door controller (drives command and sensor)
// slave : the motor block (drives status)
interface motor_puertas_if;
    logic [1:0] salida_puertas;
    logic       sensor;
    logic [1:0] puertas;
    logic       timeout;
    logic [7:0] posicion;
    logic       cmd_invalido;

    modport master (
        output salida_puertas,
        output sensor,
        input  puertas,
        input  timeout,
        input  posicion,
        input  cmd_invalido
    );

    modport slave (
        input  salida_puertas,
        input  sensor,
        output puertas,
        output timeout,
        output posicion,
        output cmd_invalido
    );
endinterface

// File: rtl/motor_puertas.sv
// rtl/motor_puertas.sv - door motor FSM with travel position and open-dwell timeout
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    motor_puertas_if.slave (command/sensor in, status out)
// Parameters:
//   T_MOV     travel time in cycles between closed and open (1..255)
//   T_ABIERTA dwell cycles fully open before timeout asserts (1..65535)
// Build option:
//   SENSOR_REVERSA_EN  when defined, an obstruction while closing reverses the doors
module motor_puertas #(
    parameter int unsigned T_MOV     = 16,
    parameter int unsigned T_ABIERTA = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    motor_puertas_if.slave   bus
);

    localparam logic [7:0]  POS_MAX   = 8'(T_MOV);
    localparam logic [15:0] DWELL_MAX = 16'(T_ABIERTA);

    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        CERRANDO = 2'b10,
        ABRIENDO = 2'b11
    } estado_t;

    estado_t     state_q, state_n;
    logic [7:0]  pos_q, pos_n;
    logic [15:0] dwell_q, dwell_n;
    logic        timeout_q, timeout_n;
    logic        inv_q, inv_n;

    logic        abrir, cerrar, reversa;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CERRADA;
            pos_q     <= 8'd0;
            dwell_q   <= 16'd0;
            timeout_q <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            pos_q     <= pos_n;
            dwell_q   <= dwell_n;
            timeout_q <= timeout_n;
            inv_q     <= inv_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pos_n   = pos_q;
        dwell_n = dwell_q;

        // 11 decodes as neither open nor close, so it behaves exactly like 00.
        abrir = (bus.salida_puertas == 2'b01);
        cerrar = (bus.salida_puertas == 2'b10);
        inv_n = (bus.salida_puertas == 2'b11);

`ifdef SENSOR_REVERSA_EN
        reversa = abrir || bus.sensor;
`else
        reversa = abrir;
`endif

        case (state_q)
            CERRADA: begin
                pos_n = 8'd0;
                if (abrir) state_n = ABRIENDO;
            end
            ABRIENDO: begin
                if (cerrar) begin
                    state_n = CERRANDO;
                end else if (pos_q >= POS_MAX - 8'd1) begin
                    // Also catches a reversal that happened right at the open end.
                    pos_n   = POS_MAX;
                    state_n = ABIERTA;
                    dwell_n = 16'd0;
                end else begin
                    pos_n = pos_q + 8'd1;
                end
            end
            ABIERTA: begin
                if (cerrar) begin
                    state_n = CERRANDO;
                end else if (abrir || bus.sensor) begin
                    dwell_n = 16'd0;
                end else if (dwell_q != DWELL_MAX) begin
                    dwell_n = dwell_q + 16'd1;
                end
            end
            CERRANDO: begin
                if (reversa) begin
                    state_n = ABRIENDO;
                end else if (pos_q <= 8'd1) begin
                    // pos 0 is possible after reversing at the very start of opening.
                    pos_n   = 8'd0;
                    state_n = CERRADA;
                end else begin
                    pos_n = pos_q - 8'd1;
                end
            end
            default: state_n = CERRADA;
        endcase

        timeout_n = (state_n == ABIERTA) && (dwell_n == DWELL_MAX);
    end

    assign bus.puertas      = state_q;
    assign bus.posicion     = pos_q;
    assign bus.timeout      = timeout_q;
    assign bus.cmd_invalido = inv_q;

endmodule

// File: doc/motor_puertas.md
MOTOR_PUERTAS -- requirements
Module: motor_puertas

Interface
REQ-001 Parameter T_MOV, default 16, door travel time in clock cycles between fully closed and fully open; legal range 1..255.
REQ-002 Parameter T_ABIERTA, default 100, dwell cycles with doors fully open before timeout asserts; legal range 1..65535.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 salida_puertas  in  2  door command: 01 open, 10 close, 00 nothing, 11 illegal.
REQ-006 sensor  in  1  obstruction between doors: 1 sensed, 0 clear.
REQ-007 puertas  out  2  door status: 00 fully closed, 01 fully open, 10 closing, 11 opening.
REQ-008 timeout  out  1  open-dwell timeout, level.
REQ-009 posicion  out  8  current door position: 0 = closed, T_MOV = open.
REQ-010 cmd_invalido  out  1  one-cycle pulse on an illegal command.

Function
REQ-011 The block SHALL implement states CERRADA, ABIERTA, CERRANDO and ABRIENDO, with puertas encoded 00, 01, 10 and 11 respectively.
REQ-012 All outputs SHALL be registered; a command sampled at edge N affects outputs after edge N.
REQ-013 CERRADA: on cmd 01, go to ABRIENDO; otherwise hold, with posicion = 0.
REQ-014 ABRIENDO: posicion +1 per cycle; on reaching T_MOV, go to ABIERTA on that same edge; cmd 00 continues opening.
REQ-015 ABRIENDO with cmd 10: go to CERRANDO, keeping posicion (reversal, no jump).
REQ-016 ABIERTA: dwell counter (16 bit) cleared on entry, +1 per cycle, saturating at T_ABIERTA.
REQ-017 timeout SHALL be 1 exactly while in ABIERTA and dwell counter == T_ABIERTA; 0 in all other states.
REQ-018 ABIERTA with cmd 01 or sensor = 1: clear dwell counter, which deasserts timeout on the next edge.
REQ-019 ABIERTA with cmd 10: go to CERRANDO; cmd 10 takes priority over sensor in this state.
REQ-020 CERRANDO: posicion -1 per cycle; on reaching 0, go to CERRADA on that same edge; cmd 00 continues closing.
REQ-021 CERRANDO with cmd 01: go to ABRIENDO, keeping posicion.
REQ-022 cmd 11 SHALL be treated as 00 in every state and SHALL pulse cmd_invalido for one cycle.
REQ-023 posicion SHALL never leave 0..T_MOV; no wrap-around.
REQ-024 T_MOV = 1: a full open or a full close SHALL take exactly one cycle in ABRIENDO or CERRANDO.

Reset
REQ-025 Asserting rst_n low SHALL, immediately and regardless of the clock, force CERRADA, posicion = 0, dwell counter = 0, timeout = 0, cmd_invalido = 0, puertas = 00.
REQ-026 Reset mid-travel SHALL abandon the motion; after release the block SHALL sit in CERRADA until commanded.

Configuration
REQ-027 Macro SENSOR_REVERSA_EN, when defined: sensor = 1 in CERRANDO forces ABRIENDO on that edge, with priority over any command.
REQ-028 Macro SENSOR_REVERSA_EN, when undefined: sensor is ignored in CERRANDO, and reversal is solely the controller's job via cmd 01.

Verification
REQ-029 T_MOV=4, reset then cmd 01 for 1 cycle, then 00 -> puertas 11 for 4 cycles, posicion 1,2,3,4, then puertas 01.
REQ-030 T_ABIERTA=5, doors open, cmd 00 -> timeout rises 5 edges after entering ABIERTA; cmd 01 one cycle -> timeout 0 next cycle, reasserts 5 later.
REQ-031 T_MOV=4, closing at posicion 2, cmd 01 -> puertas 11, posicion 3,4, then 01.
REQ-032 Closing at posicion 3, sensor=1, cmd 00 -> with SENSOR_REVERSA_EN: puertas 11, posicion 4; without it: puertas 10, posicion 2.
REQ-033 cmd 11 in any state -> cmd_invalido pulses 1 cycle, state and posicion behave as for 00.
REQ-034 rst_n low asynchronously while opening at posicion 2 -> puertas 00, posicion 0, timeout 0 before the next clk edge.
